// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - pipeline-stage register with valid/ready handshake, optional skid entry, flush and bubble zeroing
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 113,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CTRL_W-1:0]   main_ctrl_q;
  logic [DATA_W-1:0]   main_data_q;
  logic [CTRL_W-1:0]   skid_ctrl_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic                main_valid;
  logic                skid_valid;
  logic                in_fire;
  logic                out_fire;

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  generate
    if (SKID) begin : g_skid_ready
      // Registered-only ready: breaks the ready chain between stages.
      assign in_ready_o = !skid_valid;
    end else begin : g_comb_ready
      assign in_ready_o = !main_valid || out_ready_i;
    end
  endgenerate

  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = main_valid && out_ready_i;
  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_ctrl_q;
  assign out_data_o  = main_data_q;
  assign count_o     = state_q;

  // Main ctrl is cleared whenever the main entry empties, so bubbles carry zero control.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush_i) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_q     <= ST_ONE;
            main_ctrl_q <= in_ctrl_i;
            main_data_q <= in_data_i;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_q <= in_ctrl_i;
            main_data_q <= in_data_i;
          end else if (in_fire) begin
            state_q     <= ST_FULL;
            skid_ctrl_q <= in_ctrl_i;
            skid_data_q <= in_data_i;
          end else if (out_fire) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_q     <= ST_ONE;
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          main_ctrl_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - bench for pipe_stage_skid_reg, SKID=0 and SKID=1 instances against a FIFO scoreboard
module tb_pipe_stage_skid_reg;

  localparam int CW = 10;
  localparam int DW = 113;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    logic          vin;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ordy;
    logic          exp_ov;
    logic [1:0]    exp_cnt;
    logic          exp_rdy;
    logic [DW-1:0] exp_d;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          rdy0, ov0, rdy1, ov1;
  logic [CW-1:0] oc0, oc1;
  logic [DW-1:0] od0, od1;
  logic [1:0]    cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  beat_t         sb [2][$];
  logic [DW-1:0] last_d [2];

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_noskid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_ctrl_o(oc0), .out_data_o(od0), .count_o(cnt0)
  );

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_ctrl_o(oc1), .out_data_o(od1), .count_o(cnt1)
  );

  task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 10'h3FF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb[k].delete();
      last_d[k] = '0;
    end
  endtask

  // One cycle: drive, check both instances against the scoreboard at negedge, advance the model.
  task automatic cycle(input logic vin, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    in_valid = vin; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic          e_ov, e_rdy, a_ov, a_rdy;
      logic [CW-1:0] e_c, a_c;
      logic [DW-1:0] e_d, a_d;
      logic [1:0]    a_cnt;
      int            sz;
      beat_t         nb;
      sz    = sb[k].size();
      e_ov  = (sz > 0);
      e_c   = e_ov ? sb[k][0].c : '0;
      e_d   = e_ov ? sb[k][0].d : last_d[k];
      e_rdy = (k == 1) ? (sz < 2) : (sz == 0 || ordy);
      a_ov  = (k == 1) ? ov1 : ov0;
      a_rdy = (k == 1) ? rdy1 : rdy0;
      a_c   = (k == 1) ? oc1 : oc0;
      a_d   = (k == 1) ? od1 : od0;
      a_cnt = (k == 1) ? cnt1 : cnt0;
      chk("out_valid", k, 128'(a_ov), 128'(e_ov));
      chk("out_ctrl", k, 128'(a_c), 128'(e_c));
      chk("out_data", k, 128'(a_d), 128'(e_d));
      chk("count", k, 128'(a_cnt), 128'(sz));
      chk("in_ready", k, 128'(a_rdy), 128'(e_rdy));
      if (e_ov) last_d[k] = sb[k][0].d;
      if (fl) begin
        sb[k].delete();
      end else begin
        if (e_ov && ordy) void'(sb[k].pop_front());
        if (vin && e_rdy) begin
          nb.c = c; nb.d = d;
          sb[k].push_back(nb);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt [8];

  initial begin
    // Back-pressure on the skid instance from empty: A, B fill it, C waits upstream.
    vt[0] = '{1'b1, 10'h011, 113'hA, 1'b0, 1'b0, 2'd0, 1'b1, 113'h0};
    vt[1] = '{1'b1, 10'h022, 113'hB, 1'b0, 1'b1, 2'd1, 1'b1, 113'hA};
    vt[2] = '{1'b1, 10'h033, 113'hC, 1'b0, 1'b1, 2'd2, 1'b0, 113'hA};
    vt[3] = '{1'b1, 10'h033, 113'hC, 1'b0, 1'b1, 2'd2, 1'b0, 113'hA};
    vt[4] = '{1'b1, 10'h033, 113'hC, 1'b1, 1'b1, 2'd2, 1'b0, 113'hA};
    vt[5] = '{1'b1, 10'h033, 113'hC, 1'b1, 1'b1, 2'd1, 1'b1, 113'hB};
    vt[6] = '{1'b0, 10'h000, 113'h0, 1'b1, 1'b1, 2'd1, 1'b1, 113'hC};
    vt[7] = '{1'b0, 10'h000, 113'h0, 1'b1, 1'b0, 2'd0, 1'b1, 113'h0};

    do_reset();
    cycle(1'b0, '0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      in_valid = vt[i].vin; in_ctrl = vt[i].c; in_data = vt[i].d; out_ready = vt[i].ordy;
      #2;
      chk("tbl_valid", 1, 128'(ov1), 128'(vt[i].exp_ov));
      chk("tbl_count", 1, 128'(cnt1), 128'(vt[i].exp_cnt));
      chk("tbl_ready", 1, 128'(rdy1), 128'(vt[i].exp_rdy));
      if (vt[i].exp_ov) chk("tbl_data", 1, 128'(od1), 128'(vt[i].exp_d));
      cycle(vt[i].vin, vt[i].c, vt[i].d, vt[i].ordy, 1'b0);
    end

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) cycle(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill skid instance, then flush with a colliding beat 0xD.
    cycle(1'b1, 10'h155, DW'(1), 1'b0, 1'b0);
    cycle(1'b1, 10'h155, DW'(2), 1'b0, 1'b0);
    #2;
    out_ready = 1'b1;
    #1;
    chk("ready_no_comb_path", 1, 128'(rdy1), 128'(1'b0));
    cycle(1'b1, 10'h0DD, DW'(13), 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Combinational ready of the single-entry instance with out_ready toggling.
    for (int i = 0; i < 6; i++) cycle(1'b1, CW'(i), DW'(32 + i), (i % 2) == 0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset while FULL drops both entries.
    cycle(1'b1, 10'h0AA, DW'(7), 1'b0, 1'b0);
    cycle(1'b1, 10'h0BB, DW'(8), 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 9) < 7, CW'($urandom_range(0, 1023)), r[DW-1:0],
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
# pipe_stage_skid_reg

Parametrised pipeline-stage register that replaces the fixed, always-loading inter-stage latches between CPU pipeline stages. It carries a split payload (control field plus data field) with a valid/ready handshake, optional 2-entry skid buffering, synchronous flush for branch/hazard squash, and automatic bubble insertion. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB, so a hazard unit can stall or squash any stage without per-signal muxing.

## Interface
- CTRL_W, 10: control-field width (RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUOp…); zeroed on bubble.
- DATA_W, 113: data-field width (e.g. RSdata, RTdata, imm, RS/RT/RD addr, funct); never zeroed except by reset.
- SKID, 1: 1 = 2-entry skid buffer with registered ready; 0 = single entry with combinational ready.

- clk_i  in  1  clock; all state changes on rising edge only.
- rst_i  in  1  synchronous reset, active-low.
- flush_i  in  1  squash all held entries this edge.
- in_valid_i  in  1  upstream has a beat.
- in_ready_o  out  1  block can accept a beat.
- in_ctrl_i  in  CTRL_W  upstream control field.
- in_data_i  in  DATA_W  upstream data field.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts head.
- out_ctrl_o  out  CTRL_W  head control; all-zero whenever out_valid_o=0.
- out_data_o  out  DATA_W  head data; holds last value when invalid.
- count_o  out  2  occupancy 0..2 (SKID=0: 0..1).

## Operation
- Fire definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: main entry (drives outputs) + skid entry (SKID=1 only); each entry has a valid bit, ctrl and data regs.
- in_ready_o: SKID=1 → !skid_valid (function of register state only); SKID=0 → !main_valid | out_ready_i.
- States (SKID=1), by count: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: in_fire → ONE, beat into main.
  - ONE: in_fire & out_fire → ONE, beat into main; in_fire & !out_fire → FULL, beat into skid; !in_fire & out_fire → EMPTY.
  - FULL: in_ready_o=0; out_fire → ONE, skid moves to main; else hold.
- SKID=0: main loads on in_fire; clears valid on out_fire without in_fire.
- Ordering strictly FIFO; no beat duplicated or dropped except by flush.
- flush_i=1: next edge clears both valid bits, zeroes main ctrl and skid ctrl, count→0; a same-cycle in_fire beat is discarded; a same-cycle out_fire is considered consumed downstream (downstream also honours flush).
- Bubble: out_ctrl_o is forced to 0 whenever main_valid=0 (registered zeroing, not a combinational AND on the output path); out_data_o keeps stale data.
- Priority: rst_i low > flush_i > normal handshake.

## Timing
- Reset (rst_i=0 at edge): out_valid_o=0, out_ctrl_o=0, out_data_o=0, skid regs 0, count_o=0; in_ready_o=1 (both modes) from the following cycle on.
- Latency: beat accepted at edge N appears on out_* after edge N (visible in cycle N+1); 1 cycle.
- Throughput: 1 beat/cycle sustained when out_ready_i=1 in both modes.
- SKID=1: in_ready_o has no combinational path from out_ready_i; it drops the cycle after FULL is entered and rises the cycle after the first out_fire from FULL.
- Reset or flush mid-FULL: both entries lost on that edge; no partial transfer.
- in_valid_i may drop without handshake; payload sampled only on in_fire.

## Test plan
- Reset: hold rst_i=0 two edges with in_valid_i=1, in_ctrl_i=0x3FF → out_valid_o=0, out_ctrl_o=0, count_o=0, in_ready_o=1 after release.
- Streaming: out_ready_i=1, beats D=1..8 each cycle → out_data_o 1..8 in order one cycle delayed, count_o=1 steady, in_ready_o never low.
- Back-pressure (SKID=1): out_ready_i=0, push 0xA,0xB → count_o=2, in_ready_o=0, third beat 0xC held upstream; raise out_ready_i → outputs 0xA,0xB,0xC, no loss.
- Flush: FULL with ctrl=0x155, assert flush_i together with in_valid_i=1 (0xD) → next cycle out_valid_o=0, out_ctrl_o=0, count_o=0, 0xD never appears.
- SKID=0: out_ready_i toggles 1,0,1 with continuous input → in_ready_o mirrors (!main_valid|out_ready_i) combinationally, order preserved, max count_o=1.
- Random: random in_valid_i/out_ready_i/flush_i 10k cycles vs. scoreboard queue → exact order match, out_ctrl_o=0 whenever out_valid_o=0.
